// File: rtl/formant_tsum_pkg.sv
// rtl/formant_tsum_pkg.sv - shared parameters, types and cosine table generator for formant_tsum
package formant_tsum_pkg;

  localparam int BIT_WIDTH = 32;
  localparam int I         = 160;
  localparam int FORMANTS  = 5;
  localparam int NU_VALUES = 3;
  localparam int COS_FRAC  = 15;

  localparam int BIN_W   = $clog2(I);
  localparam int ADDR_W  = $clog2(2 * I);
  localparam int SEG_W   = $clog2(FORMANTS + 1);
  localparam int PROD_W  = BIT_WIDTH + COS_FRAC + 1;
  localparam int COS_ONE = (1 << COS_FRAC) - 1;

  typedef logic [BIN_W-1:0]             bound_t;
  typedef bound_t [FORMANTS-1:0]        bounds_t;
  typedef logic signed [BIT_WIDTH-1:0]  tval_t;
  typedef tval_t [NU_VALUES-1:0]        t_vals_t;
  typedef logic signed [COS_FRAC:0]     cos_t;
  typedef logic [ADDR_W-1:0]            lut_addr_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // round(COS_ONE*cos(pi*k/I)) by quarter-wave folding and a Q30 Taylor series,
  // integer-only so the table folds to constants at elaboration.
  function automatic cos_t cos_entry(input int k);
    longint pi_q30;
    longint x;
    longint term;
    longint sum;
    longint val;
    int     m;
    bit     neg;
    pi_q30 = 64'sd3373259426;
    m      = k;
    neg    = 1'b0;
    if (m > I) m = 2 * I - m;
    if (2 * m > I) begin
      m   = I - m;
      neg = 1'b1;
    end
    x    = (pi_q30 * longint'(m)) / longint'(I);
    term = longint'(1) <<< 30;
    sum  = term;
    for (int n = 1; n <= 8; n++) begin
      term = (term * x) >>> 30;
      term = (term * x) >>> 30;
      term = -term / longint'((2 * n - 1) * (2 * n));
      sum  = sum + term;
    end
    val = (sum * longint'(COS_ONE) + (longint'(1) <<< 29)) >>> 30;
    return neg ? cos_t'(-val) : cos_t'(val);
  endfunction

endpackage

// File: rtl/formant_tsum_if.sv
// rtl/formant_tsum_if.sv - bin/boundary input and T-sum output bundle of formant_tsum
interface formant_tsum_if;
  import formant_tsum_pkg::*;

  logic                 frame_start;
  bounds_t              seg_bounds;
  logic                 bin_valid;
  logic [BIT_WIDTH-1:0] bin_power;
  logic                 tsum_start;
  logic                 tsum_valid;
  t_vals_t              tsum_vals;
  logic                 frame_done;

  modport master (
    output frame_start, seg_bounds, bin_valid, bin_power,
    input  tsum_start, tsum_valid, tsum_vals, frame_done
  );

  modport slave (
    input  frame_start, seg_bounds, bin_valid, bin_power,
    output tsum_start, tsum_valid, tsum_vals, frame_done
  );

endinterface

// File: rtl/formant_tsum_cos_lut.sv
// rtl/formant_tsum_cos_lut.sv - dual-read cosine ROM over 2I points, registered outputs
module formant_tsum_cos_lut
  import formant_tsum_pkg::*;
(
  input  logic      clk_in,
  input  lut_addr_t addr_a,
  input  lut_addr_t addr_b,
  output cos_t      data_a,
  output cos_t      data_b
);

  cos_t rom [2*I];
  cos_t data_a_d, data_a_q;
  cos_t data_b_d, data_b_q;

  for (genvar k = 0; k < 2 * I; k++) begin : g_rom
    localparam cos_t VAL = cos_entry(k);
    assign rom[k] = VAL;
  end

  always_comb begin
    data_a_d = rom[addr_a];
    data_b_d = rom[addr_b];
  end

  always_ff @(posedge clk_in) begin
    data_a_q <= data_a_d;
    data_b_q <= data_b_d;
  end

  assign data_a = data_a_q;
  assign data_b = data_b_q;

endmodule

// File: rtl/formant_tsum.sv
// rtl/formant_tsum.sv - cosine-weighted cumulative spectrum sums per formant segment
module formant_tsum
  import formant_tsum_pkg::*;
(
  input logic           clk_in,
  input logic           rst_in,
  formant_tsum_if.slave bus
);

  state_t               state_d, state_q;
  bounds_t              bounds_d, bounds_q;
  bound_t               bin_cnt_d, bin_cnt_q;
  logic [SEG_W-1:0]     seg_idx_d, seg_idx_q;
  logic                 v1_d, v1_q, last1_d, last1_q, fin1_d, fin1_q;
  logic [BIT_WIDTH-1:0] pow1_d, pow1_q;
  logic                 v2_d, v2_q, last2_d, last2_q, fin2_d, fin2_q;
  t_vals_t              p_d, p_q;
  t_vals_t              acc_d, acc_q;
  logic                 last3_d, last3_q, fin3_d, fin3_q;
  t_vals_t              vals_d, vals_q;
  logic                 start_d, start_q, valid_d, valid_q, done_d, done_q;

  logic                 accept, hit;
  bound_t               cur_bin;
  logic [SEG_W-1:0]     cur_seg;
  bounds_t              cur_bounds;
  lut_addr_t            a1, a2;
  cos_t                 c1, c2;
  logic signed [PROD_W-1:0] pow_ext, c1_ext, c2_ext, prod1, prod2;

  // A frame_start cycle sees bin 0 and the freshly presented bounds.
  always_comb begin
    cur_bounds = bus.frame_start ? bus.seg_bounds : bounds_q;
    cur_seg    = bus.frame_start ? '0 : seg_idx_q;
    cur_bin    = bus.frame_start ? '0 : bin_cnt_q;
    accept     = bus.bin_valid && (bus.frame_start || state_q == ST_RUN);
    hit        = accept && (cur_seg < SEG_W'(FORMANTS)) && (cur_bin == cur_bounds[cur_seg]);
    a1         = lut_addr_t'(cur_bin);
    a2         = lut_addr_t'({cur_bin, 1'b0});
  end

  formant_tsum_cos_lut u_cos_lut (
    .clk_in (clk_in),
    .addr_a (a1),
    .addr_b (a2),
    .data_a (c1),
    .data_b (c2)
  );

  assign pow_ext = $signed({{(PROD_W-BIT_WIDTH){1'b0}}, pow1_q});
  assign c1_ext  = $signed({{(PROD_W-COS_FRAC-1){c1[COS_FRAC]}}, c1});
  assign c2_ext  = $signed({{(PROD_W-COS_FRAC-1){c2[COS_FRAC]}}, c2});
  assign prod1   = pow_ext * c1_ext;
  assign prod2   = pow_ext * c2_ext;

  always_comb begin
    state_d   = state_q;
    bounds_d  = bounds_q;
    bin_cnt_d = bin_cnt_q;
    seg_idx_d = seg_idx_q;

    v1_d    = accept;
    last1_d = hit;
    fin1_d  = hit && (cur_seg == SEG_W'(FORMANTS - 1));
    pow1_d  = bus.bin_power;

    v2_d    = v1_q;
    last2_d = v1_q && last1_q;
    fin2_d  = v1_q && fin1_q;
    p_d[0]  = tval_t'(pow1_q);
    p_d[1]  = tval_t'(prod1 >>> COS_FRAC);
    p_d[2]  = tval_t'(prod2 >>> COS_FRAC);

    acc_d = acc_q;
    if (v2_q) begin
      for (int nu = 0; nu < NU_VALUES; nu++) begin
        acc_d[nu] = acc_q[nu] + p_q[nu];
      end
    end
    last3_d = v2_q && last2_q;
    fin3_d  = v2_q && fin2_q;

    vals_d = vals_q;
    if (last3_q) vals_d = acc_q;
    valid_d = last3_q;
    done_d  = fin3_q;
    start_d = bus.frame_start;

    if (state_q == ST_DRAIN && !v1_q && !v2_q && !last3_q) state_d = ST_IDLE;

    // Restart discards everything still in flight from the previous frame.
    if (bus.frame_start) begin
      state_d   = ST_RUN;
      bounds_d  = bus.seg_bounds;
      bin_cnt_d = '0;
      seg_idx_d = '0;
      acc_d     = '0;
      v2_d      = 1'b0;
      last2_d   = 1'b0;
      fin2_d    = 1'b0;
      last3_d   = 1'b0;
      fin3_d    = 1'b0;
      valid_d   = 1'b0;
      done_d    = 1'b0;
    end

    if (accept) begin
      bin_cnt_d = cur_bin + 1'b1;
      if (cur_bin == bound_t'(I - 1)) state_d = ST_DRAIN;
    end
    if (hit) seg_idx_d = cur_seg + 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= ST_IDLE;
      bounds_q  <= '0;
      bin_cnt_q <= '0;
      seg_idx_q <= '0;
      v1_q      <= 1'b0;
      last1_q   <= 1'b0;
      fin1_q    <= 1'b0;
      pow1_q    <= '0;
      v2_q      <= 1'b0;
      last2_q   <= 1'b0;
      fin2_q    <= 1'b0;
      p_q       <= '0;
      acc_q     <= '0;
      last3_q   <= 1'b0;
      fin3_q    <= 1'b0;
      vals_q    <= '0;
      start_q   <= 1'b0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bounds_q  <= bounds_d;
      bin_cnt_q <= bin_cnt_d;
      seg_idx_q <= seg_idx_d;
      v1_q      <= v1_d;
      last1_q   <= last1_d;
      fin1_q    <= fin1_d;
      pow1_q    <= pow1_d;
      v2_q      <= v2_d;
      last2_q   <= last2_d;
      fin2_q    <= fin2_d;
      p_q       <= p_d;
      acc_q     <= acc_d;
      last3_q   <= last3_d;
      fin3_q    <= fin3_d;
      vals_q    <= vals_d;
      start_q   <= start_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
    end
  end

  assign bus.tsum_start = start_q;
  assign bus.tsum_valid = valid_q;
  assign bus.tsum_vals  = vals_q;
  assign bus.frame_done = done_q;

endmodule

// File: tb/tb_formant_tsum.sv
// tb/tb_formant_tsum.sv - directed vector bench for formant_tsum
module tb_formant_tsum;
  import formant_tsum_pkg::*;

  typedef struct {
    int imp;
    int pwr;
    bit cnst;
    int gap;
    bit chk12;
    int e0 [5];
    int e1 [5];
    int e2 [5];
  } vec_t;

  logic clk_in = 1'b0;
  logic rst_in;
  always #5 clk_in = ~clk_in;

  formant_tsum_if dut_if ();
  formant_tsum dut (.clk_in(clk_in), .rst_in(rst_in), .bus(dut_if));

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int st_v [256][3];
  bit st_done [256];
  int st_edge [256];
  int n_strobe = 0;
  int start_edge = -1;

  // Edges are recorded as the rising edge at which a downstream stage samples the output.
  always @(negedge clk_in) begin
    if (dut_if.tsum_valid && n_strobe < 256) begin
      for (int k = 0; k < 3; k++) st_v[n_strobe][k] <= dut_if.tsum_vals[k];
      st_done[n_strobe] <= dut_if.frame_done;
      st_edge[n_strobe] <= cyc + 1;
      n_strobe          <= n_strobe + 1;
    end
    if (dut_if.tsum_start) start_edge <= cyc + 1;
  end

  int n_pass = 0;
  int n_total = 0;
  int f_edge = 0;
  int acc_edge [200];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic settle(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic start_frame(input bounds_t b);
    dut_if.frame_start = 1'b1;
    dut_if.seg_bounds  = b;
    @(posedge clk_in);
    #1;
    f_edge = cyc;
    dut_if.frame_start = 1'b0;
  endtask

  task automatic drive_bins(input int first, input int count, input int imp,
                            input int pwr, input bit cnst, input int gap);
    for (int j = 0; j < count; j++) begin
      int b;
      b = first + j;
      dut_if.bin_valid = 1'b1;
      dut_if.bin_power = (cnst || b == imp) ? pwr : 0;
      @(posedge clk_in);
      #1;
      if (b < 200) acc_edge[b] = cyc;
      dut_if.bin_valid = 1'b0;
      repeat (gap) begin
        @(posedge clk_in);
        #1;
      end
    end
  endtask

  initial begin
    vec_t    vecs [5];
    bounds_t std_b;
    bounds_t abort_b;
    int      bnd [5];
    int      base;
    int      t0_exp [5];

    std_b   = {8'd159, 8'd127, 8'd95, 8'd63, 8'd31};
    abort_b = {8'd159, 8'd140, 8'd120, 8'd100, 8'd50};
    bnd     = '{31, 63, 95, 127, 159};
    t0_exp  = '{128, 256, 384, 512, 640};

    vecs[0] = '{0,  65536, 1'b0, 0, 1'b1,
                '{65536, 65536, 65536, 65536, 65536},
                '{65534, 65534, 65534, 65534, 65534},
                '{65534, 65534, 65534, 65534, 65534}};
    vecs[1] = '{80, 65536, 1'b0, 0, 1'b1,
                '{0, 0, 65536, 65536, 65536},
                '{0, 0, 0, 0, 0},
                '{0, 0, -65534, -65534, -65534}};
    vecs[2] = '{40, 65536, 1'b0, 0, 1'b1,
                '{0, 65536, 65536, 65536, 65536},
                '{0, 46340, 46340, 46340, 46340},
                '{0, 0, 0, 0, 0}};
    vecs[3] = '{-1, 4, 1'b1, 2, 1'b0,
                '{128, 256, 384, 512, 640}, '{0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0}};
    vecs[4] = '{-1, 4, 1'b1, 0, 1'b0,
                '{128, 256, 384, 512, 640}, '{0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0}};

    dut_if.frame_start = 1'b0;
    dut_if.seg_bounds  = '0;
    dut_if.bin_valid   = 1'b0;
    dut_if.bin_power   = '0;
    rst_in = 1'b1;
    settle(3);
    check("rst_start", int'(dut_if.tsum_start), 0);
    check("rst_valid", int'(dut_if.tsum_valid), 0);
    check("rst_done",  int'(dut_if.frame_done), 0);
    check("rst_vals0", dut_if.tsum_vals[0], 0);
    rst_in = 1'b0;
    settle(2);

    for (int v = 0; v < 5; v++) begin
      base = n_strobe;
      start_frame(std_b);
      drive_bins(0, I, vecs[v].imp, vecs[v].pwr, vecs[v].cnst, vecs[v].gap);
      settle(12);
      check($sformatf("v%0d_start_lat", v), start_edge - f_edge, 1);
      check($sformatf("v%0d_n_strobe", v), n_strobe - base, 5);
      for (int s = 0; s < 5; s++) begin
        check($sformatf("v%0d_s%0d_t0", v, s), st_v[base+s][0], vecs[v].e0[s]);
        if (vecs[v].chk12) begin
          check($sformatf("v%0d_s%0d_t1", v, s), st_v[base+s][1], vecs[v].e1[s]);
          check($sformatf("v%0d_s%0d_t2", v, s), st_v[base+s][2], vecs[v].e2[s]);
        end
        check($sformatf("v%0d_s%0d_done", v, s), int'(st_done[base+s]), (s == 4) ? 1 : 0);
        check($sformatf("v%0d_s%0d_lat", v, s), st_edge[base+s] - acc_edge[bnd[s]], 4);
      end
    end

    // Abort after bin 50 (boundary bin in flight); new frame's bin 0 arrives with frame_start.
    base = n_strobe;
    start_frame(abort_b);
    drive_bins(0, 51, 5, 1000, 1'b0, 0);
    dut_if.frame_start = 1'b1;
    dut_if.seg_bounds  = std_b;
    dut_if.bin_valid   = 1'b1;
    dut_if.bin_power   = 65536;
    @(posedge clk_in);
    #1;
    f_edge      = cyc;
    acc_edge[0] = cyc;
    dut_if.frame_start = 1'b0;
    dut_if.bin_valid   = 1'b0;
    drive_bins(1, I - 1, 0, 65536, 1'b0, 0);
    settle(12);
    check("abort_start_lat", start_edge - f_edge, 1);
    check("abort_n_strobe", n_strobe - base, 5);
    check("abort_lat0", st_edge[base] - acc_edge[31], 4);
    for (int s = 0; s < 5; s++) begin
      check($sformatf("abort_s%0d_t0", s), st_v[base+s][0], 65536);
      check($sformatf("abort_s%0d_t1", s), st_v[base+s][1], 65534);
      check($sformatf("abort_s%0d_t2", s), st_v[base+s][2], 65534);
      check($sformatf("abort_s%0d_done", s), int'(st_done[base+s]), (s == 4) ? 1 : 0);
    end

    // Reset mid-frame with the bin-63 boundary still in the pipeline.
    start_frame(std_b);
    drive_bins(0, 65, -1, 4, 1'b1, 0);
    base = n_strobe;
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;
    check("midrst_valid", int'(dut_if.tsum_valid), 0);
    check("midrst_vals0", dut_if.tsum_vals[0], 0);
    check("midrst_done",  int'(dut_if.frame_done), 0);
    rst_in = 1'b0;
    drive_bins(0, 20, -1, 4, 1'b1, 0);
    settle(10);
    check("idle_no_strobe", n_strobe - base, 0);
    check("idle_vals0", dut_if.tsum_vals[0], 0);

    base = n_strobe;
    start_frame(std_b);
    drive_bins(0, 200, -1, 4, 1'b1, 0);
    settle(12);
    check("over_n_strobe", n_strobe - base, 5);
    for (int s = 0; s < 5; s++) begin
      check($sformatf("over_s%0d_t0", s), st_v[base+s][0], t0_exp[s]);
      check($sformatf("over_s%0d_done", s), int'(st_done[base+s]), (s == 4) ? 1 : 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/formant_tsum.md
Name: formant_tsum

Overview:
- Upstream feeder for the phi stage.
- Consumes one frame of I power-spectrum bins plus FORMANTS segment right-boundaries per frame.
- Accumulates cosine-weighted cumulative sums T_nu(k) = sum over bins i<=bound[k] of P(i)*cos(nu*pi*i/I), for nu = 0..2.
- Emits tsum_start once per frame, then one tsum_valid strobe per segment carrying the three cumulative sums. This is exactly the start/valid/T_vals protocol the phi stage ingests.

Parameters:
- BIT_WIDTH, 32, width of bin power and of each T value.
- I, 160, bins per frame.
- FORMANTS, 5, segments per frame.
- NU_VALUES, 3, sums per segment; only 3 is supported.
- COS_FRAC, 15, fractional bits of the signed cosine LUT entries (Q1.COS_FRAC).

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  synchronous active-high reset.
- frame_start  in  1  one-cycle pulse; begins a new frame and latches seg_bounds.
- seg_bounds  in  FORMANTS x $clog2(I)  inclusive right-end bin index per segment; strictly increasing; last = I-1.
- bin_valid  in  1  bin_power is valid this cycle.
- bin_power  in  BIT_WIDTH  unsigned bin power; MSB must be 0.
- tsum_start  out  1  one-cycle pulse, 1 cycle after frame_start.
- tsum_valid  out  1  one-cycle strobe per completed segment.
- tsum_vals  out  NU_VALUES x BIT_WIDTH signed  cumulative T_0, T_1, T_2 through the current segment's boundary; held between strobes.
- frame_done  out  1  one-cycle pulse coincident with the FORMANTS-th tsum_valid.

Behaviour:
- Reset: all outputs 0; accumulators 0; bin counter 0; FSM to IDLE; pipeline valid bits cleared.
- FSM states:
  - IDLE: bin_valid ignored. frame_start -> RUN.
  - RUN: bins counted. After bin I-1 is accepted -> DRAIN.
  - DRAIN: waits for the pipeline to empty, then -> IDLE.
- On frame_start (any state):
  - latch seg_bounds; clear the three accumulators, bin counter and segment index;
  - flush in-flight pipeline stages, so no tsum_valid is produced for an aborted frame;
  - enter RUN; tsum_start=1 on the next cycle.
- frame_start and bin_valid in the same cycle: that bin is bin 0 of the new frame.
- Bin index i is implicit: a counter incremented on each accepted bin_valid in RUN. bin_valid while in IDLE/DRAIN (more than I bins) is ignored.
- Pipeline (fixed, no stalls; bins may arrive every cycle):
  - S0 (accept cycle): compute LUT indices a1 = i and a2 = (2i) mod 2I; compute flag last = (i == seg_bounds[seg_idx]).
  - S1: registered LUT reads c1 = cos(pi*a1/I), c2 = cos(pi*a2/I); power registered alongside.
  - S2: signed products p0 = power, p1 = (power*c1) >>> COS_FRAC, p2 = (power*c2) >>> COS_FRAC.
    - product width BIT_WIDTH+COS_FRAC+1;
    - arithmetic shift (floor);
    - truncate to BIT_WIDTH.
  - S3: acc_nu += p_nu, wrapping mod 2^BIT_WIDTH. If last: tsum_vals <= the updated acc values and tsum_valid=1 next cycle.
- Latency: tsum_valid is asserted 4 cycles after the clk edge that accepted the boundary bin.
- Segment index increments when a last-flagged bin is accepted. frame_done accompanies the FORMANTS-th strobe.
- Sums are cumulative over the frame, not per-segment; the downstream stage differences consecutive segments.
- LUT entries = round(32767*cos(pi*k/I)) for k = 0..2I-1, so cos(0)=32767 and cos(pi)=-32767.
- Illegal seg_bounds (non-increasing): a segment whose boundary is never matched is skipped and never strobed. No recovery is required beyond the next frame_start.

Decomposition:
- Package formant_pkg: BIT_WIDTH, I, FORMANTS, NU_VALUES, COS_FRAC; typedef t_vals_t (NU_VALUES x BIT_WIDTH signed); typedef bound_t ($clog2(I) bits); FSM state enum.
- Sub-module cos_lut:
  - dual read port, 1-cycle registered output;
  - 2I entries of signed COS_FRAC+1 bits, generated from I at elaboration.

Test Plan:
- Impulse at bin 0, power 65536, bounds {31,63,95,127,159}, 160 bins back-to-back -> tsum_start 1 cycle after frame_start; 5 strobes; each tsum_vals = {65536, 65534, 65534}; frame_done on the 5th strobe.
- Impulse at bin 80, power 65536, same bounds -> strobes 1-2 = {0,0,0}; strobes 3-5 = {65536, 0, -65534}.
- Impulse at bin 40, power 65536 -> strobe 1 = {0,0,0}; strobes 2-5 = {65536, 46340, 0}. Check the boundary-bin strobe lands exactly 4 cycles after bin 63 is accepted.
- bin_valid gapped (1 bin every 3 cycles), constant power 4 -> T_0 strobes = 128, 256, 384, 512, 640; identical values to the back-to-back run.
- frame_start reasserted after bin 50 of a frame -> no strobes from the aborted frame; new frame yields exactly 5 strobes with correct values; frame_start with bin_valid in the same cycle counts that bin as bin 0.
- rst_in mid-frame, and 200 bins sent -> outputs 0; strobes only after the next frame_start; bins beyond 159 ignored, so exactly 5 strobes per frame.
